// File: rtl/itlb_refill_ctrl.sv
// ITLB refill controller: takes one miss, walks it through the PTW, checks the PTE
// and writes a victim entry. Also owns the valid vector, victim choice and SFENCE flush.
module itlb_refill_ctrl #(
  parameter int ENTRY_NUM = 32,
  parameter int MXLEN     = 32,
  parameter int VPN_W     = 20
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 miss_valid_i,
  input  logic [VPN_W-1:0]     miss_vpn_i,
  output logic                 miss_ready_o,
  output logic                 ptw_req_valid_o,
  output logic [VPN_W-1:0]     ptw_req_vpn_o,
  input  logic                 ptw_req_ready_i,
  input  logic                 ptw_resp_valid_i,
  input  logic [MXLEN-1:0]     ptw_resp_pte_i,
  input  logic                 ptw_resp_fault_i,
  input  logic                 flush_i,
  output logic [ENTRY_NUM-1:0] wr_en_o,
  output logic [MXLEN-1:0]     pte_wr_o,
  output logic [VPN_W-1:0]     vpn_wr_o,
  output logic [ENTRY_NUM-1:0] entry_valid_o,
  output logic                 refill_done_o,
  output logic                 refill_fault_o,
  output logic                 refill_killed_o
);

  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, COMMIT} state_e;

  state_e               state_q, state_d;
  logic [VPN_W-1:0]     vpn_q;
  logic [MXLEN-1:0]     pte_q;
  logic                 fault_q;
  logic                 kill_q;
  logic [ENTRY_NUM-1:0] valid_q;
  logic [PTR_W-1:0]     rr_q;
  logic [PTR_W-1:0]     victim;
  logic [ENTRY_NUM-1:0] victim_onehot;
  logic                 all_valid;
  logic                 killed;
  logic                 commit_wr;

  // flags = PTE bits {W, R, V}
  function automatic logic pte_fault(input logic [2:0] flags, input logic acc_fault);
    return acc_fault | ~flags[0] | (flags[2] & ~flags[1]);
  endfunction

  // Lowest-index invalid entry wins; round-robin pointer only once the array is full.
  always_comb begin
    all_valid     = &valid_q;
    victim        = rr_q;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) victim = PTR_W'(i);
    end
    victim_onehot         = '0;
    victim_onehot[victim] = 1'b1;
  end

  always_comb begin
    state_d         = state_q;
    miss_ready_o    = 1'b0;
    ptw_req_valid_o = 1'b0;
    ptw_req_vpn_o   = '0;
    killed          = 1'b0;
    commit_wr       = 1'b0;
    refill_done_o   = 1'b0;
    refill_fault_o  = 1'b0;
    refill_killed_o = 1'b0;
    wr_en_o         = '0;
    pte_wr_o        = '0;
    vpn_wr_o        = '0;
    unique case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) state_d = REQ;
      end
      REQ: begin
        ptw_req_valid_o = 1'b1;
        ptw_req_vpn_o   = vpn_q;
        if (ptw_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (ptw_resp_valid_i) state_d = COMMIT;
      end
      COMMIT: begin
        // A flush landing in this very cycle kills the write as well.
        killed          = kill_q | flush_i;
        commit_wr       = ~fault_q & ~killed;
        refill_done_o   = 1'b1;
        refill_fault_o  = fault_q & ~killed;
        refill_killed_o = killed;
        if (commit_wr) begin
          wr_en_o  = victim_onehot;
          pte_wr_o = pte_q;
          vpn_wr_o = vpn_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign entry_valid_o = valid_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      rr_q    <= '0;
      kill_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush_i)        valid_q <= '0;
      else if (commit_wr) valid_q <= valid_q | victim_onehot;
      if (commit_wr && all_valid)
        rr_q <= (rr_q == PTR_W'(ENTRY_NUM - 1)) ? '0 : rr_q + 1'b1;
      if (state_q == COMMIT)
        kill_q <= 1'b0;
      else if (flush_i && (state_q == REQ || state_q == WAIT))
        kill_q <= 1'b1;
      if (state_q == WAIT && ptw_resp_valid_i)
        fault_q <= pte_fault(ptw_resp_pte_i[2:0], ptw_resp_fault_i);
    end
  end

  // Refill payload registers; only read in states whose entry path reloads them.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && miss_valid_i)     vpn_q <= miss_vpn_i;
    if (state_q == WAIT && ptw_resp_valid_i) pte_q <= ptw_resp_pte_i;
  end

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Bench for itlb_refill_ctrl: vector table of refills, scoreboard queue of expected
// commits checked when refill_done_o pulses, plus fill/replace and reset sequences.
module tb_itlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        miss_valid;
  logic [19:0] miss_vpn;
  logic        miss_ready;
  logic        req_valid;
  logic [19:0] req_vpn;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_pte;
  logic        resp_fault;
  logic        flush;
  logic [31:0] wr_en;
  logic [31:0] pte_wr;
  logic [19:0] vpn_wr;
  logic [31:0] entry_valid;
  logic        done;
  logic        fault;
  logic        killed;

  itlb_refill_ctrl #(.ENTRY_NUM(32), .MXLEN(32), .VPN_W(20)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .miss_valid_i(miss_valid), .miss_vpn_i(miss_vpn), .miss_ready_o(miss_ready),
    .ptw_req_valid_o(req_valid), .ptw_req_vpn_o(req_vpn), .ptw_req_ready_i(req_ready),
    .ptw_resp_valid_i(resp_valid), .ptw_resp_pte_i(resp_pte), .ptw_resp_fault_i(resp_fault),
    .flush_i(flush), .wr_en_o(wr_en), .pte_wr_o(pte_wr), .vpn_wr_o(vpn_wr),
    .entry_valid_o(entry_valid), .refill_done_o(done), .refill_fault_o(fault),
    .refill_killed_o(killed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] vpn;
    logic [31:0] pte;
    logic        flt;
    int          rdy_dly;
    logic        flush_w;
    logic        flush_m;
    logic [31:0] exp_wr;
    logic        exp_fault;
    logic        exp_kill;
    logic [31:0] exp_valid;
  } vec_t;

  typedef struct {
    logic [31:0] wr;
    logic [31:0] pte;
    logic [19:0] vpn;
    logic        fault;
    logic        kill;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[11];
  vec_t fv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [19:0] vpn, input logic [31:0] pte, input logic flt,
                              input int dly, input logic fw, input logic fm,
                              input logic [31:0] ew, input logic ef, input logic ek,
                              input logic [31:0] ev);
    vec_t v;
    v.vpn = vpn; v.pte = pte; v.flt = flt; v.rdy_dly = dly; v.flush_w = fw; v.flush_m = fm;
    v.exp_wr = ew; v.exp_fault = ef; v.exp_kill = ek; v.exp_valid = ev;
    return v;
  endfunction

  // Scoreboard: every done pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (rstn && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        chk("sb_wr_en", 64'(wr_en), 64'(e.wr));
        chk("sb_fault", 64'(fault), 64'(e.fault));
        chk("sb_killed", 64'(killed), 64'(e.kill));
        if (e.wr != 0) begin
          chk("sb_pte_wr", 64'(pte_wr), 64'(e.pte));
          chk("sb_vpn_wr", 64'(vpn_wr), 64'(e.vpn));
        end
      end
    end else if (rstn && wr_en != 0) begin
      chk("wr_without_done", 64'(wr_en), 64'(0));
    end
  end

  task automatic do_refill(input vec_t v);
    int n;
    n = 0;
    while (!miss_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("miss_ready_idle", 64'(miss_ready), 64'(1));
    miss_valid = 1'b1;
    miss_vpn   = v.vpn;
    flush      = v.flush_m;
    @(negedge clk);
    miss_valid = 1'b0;
    flush      = 1'b0;
    if (v.flush_m) chk("flush_idle_valid", 64'(entry_valid), 64'(0));
    chk("req_valid", 64'(req_valid), 64'(1));
    chk("req_vpn", 64'(req_vpn), 64'(v.vpn));
    for (int i = 0; i < v.rdy_dly; i++) begin
      @(negedge clk);
      chk("bp_req_valid", 64'(req_valid), 64'(1));
      chk("bp_req_vpn", 64'(req_vpn), 64'(v.vpn));
      chk("bp_miss_ready", 64'(miss_ready), 64'(0));
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("wait_req_low", 64'(req_valid), 64'(0));
    if (v.flush_w) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_wait_valid", 64'(entry_valid), 64'(0));
    end
    exp_q.push_back('{wr: v.exp_wr, pte: v.pte, vpn: v.vpn, fault: v.exp_fault, kill: v.exp_kill});
    resp_valid = 1'b1;
    resp_pte   = v.pte;
    resp_fault = v.flt;
    @(negedge clk);
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    chk("done_latency", 64'(done), 64'(1));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("miss_ready_back", 64'(miss_ready), 64'(1));
    chk("valid_vec", 64'(entry_valid), 64'(v.exp_valid));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; miss_valid = 1'b0; miss_vpn = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_pte = '0; resp_fault = 1'b0; flush = 1'b0;

    tbl[0]  = mk(20'h12345, 32'h2000_00CF, 0, 0, 0, 0, 32'h1, 0, 0, 32'h1);
    tbl[1]  = mk(20'h00ABC, 32'h0000_00CE, 0, 0, 0, 0, 32'h0, 1, 0, 32'h1);
    tbl[2]  = mk(20'h00ABD, 32'h2000_00CF, 1, 0, 0, 0, 32'h0, 1, 0, 32'h1);
    tbl[3]  = mk(20'h00ABE, 32'h2000_00C5, 0, 0, 0, 0, 32'h0, 1, 0, 32'h1);
    tbl[4]  = mk(20'h11111, 32'h2000_10CF, 0, 5, 0, 0, 32'h2, 0, 0, 32'h3);
    tbl[5]  = mk(20'h22222, 32'h2000_20CF, 0, 0, 0, 0, 32'h4, 0, 0, 32'h7);
    tbl[6]  = mk(20'h33333, 32'h2000_30CF, 0, 0, 0, 0, 32'h8, 0, 0, 32'hF);
    tbl[7]  = mk(20'h44444, 32'h2000_40CF, 0, 0, 1, 0, 32'h0, 0, 1, 32'h0);
    tbl[8]  = mk(20'h55555, 32'h2000_50CF, 0, 0, 0, 0, 32'h1, 0, 0, 32'h1);
    tbl[9]  = mk(20'h66666, 32'h2000_60CF, 0, 0, 0, 1, 32'h1, 0, 0, 32'h1);
    tbl[10] = mk(20'h77777, 32'h0000_00CE, 0, 0, 1, 0, 32'h0, 0, 1, 32'h0);

    do_reset();
    chk("rst_miss_ready", 64'(miss_ready), 64'(1));
    chk("rst_req_valid", 64'(req_valid), 64'(0));
    chk("rst_req_vpn", 64'(req_vpn), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_pte_wr", 64'(pte_wr), 64'(0));
    chk("rst_vpn_wr", 64'(vpn_wr), 64'(0));
    chk("rst_valid", 64'(entry_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_fault", 64'(fault), 64'(0));
    chk("rst_killed", 64'(killed), 64'(0));

    for (int i = 0; i < 11; i++) do_refill(tbl[i]);

    // Reset while waiting on the walk, then a stale response.
    miss_valid = 1'b1; miss_vpn = 20'h0BEEF;
    @(negedge clk);
    miss_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; resp_valid = 1'b1; resp_pte = 32'h2000_00CF;
    @(negedge clk);
    resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("stale_wr_en", 64'(wr_en), 64'(0));
      chk("stale_done", 64'(done), 64'(0));
      chk("stale_miss_ready", 64'(miss_ready), 64'(1));
      @(negedge clk);
    end

    // Fill all 32 entries, then round-robin replacement through a full wrap.
    do_reset();
    for (int n = 1; n <= 65; n++) begin
      fv = mk(20'(n), 32'h3000_00CF | (32'(n) << 12), 0, 0, 0, 0,
              32'd1 << ((n <= 32) ? n - 1 : (n - 33) % 32), 0, 0,
              (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1));
      do_refill(fv);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
